// File: rtl/dm_arb_pkg.sv
// Shared types and sizing helpers for the data-memory port arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Core-index width, never narrower than one bit so a single-core build still has a port.
  function automatic int idx_width(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

  function automatic int cnt_width(input int mem_latency);
    return $clog2(mem_latency + 1);
  endfunction

  localparam int NUM_CORES_DEF   = 2;
  localparam int MEM_LATENCY_DEF = 2;
  localparam int IDX_W_DEF       = idx_width(NUM_CORES_DEF);
  localparam int CNT_W_DEF       = cnt_width(MEM_LATENCY_DEF);

endpackage

// File: rtl/dm_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int IW        = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IW-1:0]        last,
  output logic                 valid,
  output logic [IW-1:0]        idx,
  output logic [NUM_CORES-1:0] onehot
);

  int unsigned cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = (int'(last) + i) % NUM_CORES;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = IW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between several cores,
// sequencing one command at a time and returning read data with a valid pulse.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int NUM_CORES   = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_CORES-1:0]             req,
  input  logic [NUM_CORES-1:0]             we,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_CORES-1:0]             gnt,
  output logic [NUM_CORES-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             busy,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);

  localparam int IW = idx_width(NUM_CORES);
  localparam int CW = cnt_width(MEM_LATENCY);

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          last, last_n;
  logic [IW-1:0]          win, win_n;
  logic [NUM_CORES-1:0]   gnt_n, rvalid_n;
  logic [DATA_WIDTH-1:0]  rdata_n, mem_wdata_n;
  logic [ADDR_WIDTH-1:0]  mem_addr_n;
  logic                   mem_en_n, mem_we_n;

  logic                   pick_valid;
  logic [IW-1:0]          pick_idx;
  logic [NUM_CORES-1:0]   pick_onehot;

  rr_pick #(.NUM_CORES(NUM_CORES), .IW(IW)) u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_n      = last;
    win_n       = win;
    gnt_n       = '0;
    rvalid_n    = '0;
    rdata_n     = rdata;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    unique case (state)
      IDLE, RESP: begin
        // RESP arbitrates like IDLE so a waiting core is granted with no bubble.
        if (pick_valid) begin
          state_n     = ISSUE;
          win_n       = pick_idx;
          last_n      = pick_idx;
          gnt_n       = pick_onehot;
          mem_en_n    = 1'b1;
          mem_we_n    = we[pick_idx];
          mem_addr_n  = addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_n = wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (mem_we) begin
          state_n = IDLE;
        end else begin
          state_n = WAIT;
          cnt_n   = CW'(MEM_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n       = RESP;
          rdata_n       = mem_rdata;
          rvalid_n[win] = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= IW'(NUM_CORES - 1);
      win       <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last      <= last_n;
      win       <= win_n;
      gnt       <= gnt_n;
      rvalid    <= rvalid_n;
      rdata     <= rdata_n;
      busy      <= (state_n != IDLE);
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: vector table, scoreboard monitor and corner sequences.
module tb_dm_port_arbiter;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req, we;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [7:0]  rdata;
  logic        busy, mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  dm_port_arbiter #(.NUM_CORES(2), .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_LATENCY(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [1:0] gnt; logic we; logic [15:0] addr; logic [7:0] wdata; } cmd_t;
  typedef struct { logic [1:0] rvalid; logic [7:0] rdata; } rsp_t;
  typedef struct {
    int core; logic we; logic [15:0] addr; logic [7:0] wdata;
    logic [1:0] exp_gnt; logic [7:0] exp_rdata;
  } vec_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t mon_cmd;
  rsp_t mon_rsp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   tb_last  = 1;

  // Two-cycle read-latency memory; idle-cycle read data is poisoned with 8'hEE.
  logic [7:0] mem [256];
  logic [7:0] p1;
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h2C;
  always @(posedge clock) begin
    cyc       <= cyc + 1;
    p1        <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 8'hEE;
    mem_rdata <= p1;
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each bus command and each read response is matched against the queues.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      check("mem_en_matches_gnt", {63'd0, mem_en}, {63'd0, |gnt});
      if (gnt != 2'b00) begin
        if (cmd_q.size() == 0) check("unexpected_gnt", {62'd0, gnt}, 64'd0);
        else begin
          mon_cmd = cmd_q.pop_front();
          check("gnt", {62'd0, gnt}, {62'd0, mon_cmd.gnt});
          check("mem_we", {63'd0, mem_we}, {63'd0, mon_cmd.we});
          check("mem_addr", {48'd0, mem_addr}, {48'd0, mon_cmd.addr});
          if (mon_cmd.we) check("mem_wdata", {56'd0, mem_wdata}, {56'd0, mon_cmd.wdata});
        end
      end else begin
        check("mem_we_idle", {63'd0, mem_we}, 64'd0);
      end
      if (rvalid != 2'b00) begin
        if (rsp_q.size() == 0) check("unexpected_rvalid", {62'd0, rvalid}, 64'd0);
        else begin
          mon_rsp = rsp_q.pop_front();
          check("rvalid", {62'd0, rvalid}, {62'd0, mon_rsp.rvalid});
          check("rdata", {56'd0, rdata}, {56'd0, mon_rsp.rdata});
        end
      end
    end
  end

  function automatic int pick_model(input logic [1:0] r, input int last);
    for (int i = 1; i <= 2; i++) if (r[(last + i) % 2]) return (last + i) % 2;
    return -1;
  endfunction

  task automatic set_core(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
    we[c]             = w;
    addr[c*16 +: 16]  = a;
    wdata[c*8 +: 8]   = d;
    req[c]            = 1'b1;
  endtask

  task automatic push_cmd(input int c, input logic w, input logic [15:0] a, input logic [7:0] d);
    cmd_q.push_back('{gnt: 2'(1 << c), we: w, addr: a, wdata: d});
    tb_last = c;
  endtask

  task automatic wait_gnt(input int c, output int lat);
    lat = 0;
    do begin @(negedge clock); lat++; end while (!gnt[c] && lat < 30);
    if (!gnt[c]) check("gnt_timeout", {63'd0, gnt[c]}, 64'd1);
  endtask

  task automatic wait_rvalid(input int c, output int lat);
    lat = 0;
    do begin @(negedge clock); lat++; end while (!rvalid[c] && lat < 30);
    if (!rvalid[c]) check("rvalid_timeout", {63'd0, rvalid[c]}, 64'd1);
  endtask

  vec_t vecs[6];
  vec_t t;
  int   lat;
  int   grants[2];
  int   rem[2];
  int   prev_cyc;
  int   w;
  int   rv_seen;

  initial begin
    vecs[0] = '{core: 1, we: 1'b1, addr: 16'h0040, wdata: 8'hA5, exp_gnt: 2'b10, exp_rdata: 8'h00};
    vecs[1] = '{core: 0, we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp_gnt: 2'b01, exp_rdata: 8'h3C};
    vecs[2] = '{core: 1, we: 1'b0, addr: 16'h0040, wdata: 8'h00, exp_gnt: 2'b10, exp_rdata: 8'hA5};
    vecs[3] = '{core: 0, we: 1'b1, addr: 16'h0010, wdata: 8'h5A, exp_gnt: 2'b01, exp_rdata: 8'h00};
    vecs[4] = '{core: 0, we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp_gnt: 2'b01, exp_rdata: 8'h5A};
    vecs[5] = '{core: 1, we: 1'b0, addr: 16'h00FF, wdata: 8'h00, exp_gnt: 2'b10, exp_rdata: 8'hD3};

    // Reset held three cycles with both cores requesting writes.
    reset_n = 1'b0;
    req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    set_core(0, 1'b1, 16'h0100, 8'h11);
    set_core(1, 1'b1, 16'h0101, 8'h22);
    repeat (3) begin
      @(negedge clock);
      check("reset_outputs", {25'd0, gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    end
    tb_last = 1;
    push_cmd(0, 1'b1, 16'h0100, 8'h11);
    push_cmd(1, 1'b1, 16'h0101, 8'h22);
    reset_n = 1'b1;
    @(negedge clock);
    check("first_gnt_after_reset", {62'd0, gnt}, 64'd1);
    req[0] = 1'b0;
    wait_gnt(1, lat);
    check("second_write_spacing", lat, 2);
    req[1] = 1'b0;
    repeat (2) @(negedge clock);

    // Single-access vector table.
    for (int v = 0; v < 6; v++) begin
      t = vecs[v];
      set_core(t.core, t.we, t.addr, t.wdata);
      cmd_q.push_back('{gnt: t.exp_gnt, we: t.we, addr: t.addr, wdata: t.wdata});
      tb_last = t.core;
      if (!t.we) rsp_q.push_back('{rvalid: t.exp_gnt, rdata: t.exp_rdata});
      wait_gnt(t.core, lat);
      check("vec_gnt_latency", lat, 1);
      check("vec_gnt", {62'd0, gnt}, {62'd0, t.exp_gnt});
      req[t.core] = 1'b0;
      if (!t.we) begin
        wait_rvalid(t.core, lat);
        check("vec_read_latency", lat, 3);
        check("vec_rdata", {56'd0, rdata}, {56'd0, t.exp_rdata});
      end
      repeat (3) @(negedge clock);
    end

    // Back-to-back read: re-request during the RESP cycle.
    set_core(0, 1'b0, 16'h0020, 8'h00);
    push_cmd(0, 1'b0, 16'h0020, 8'h00);
    rsp_q.push_back('{rvalid: 2'b01, rdata: 8'h0C});
    wait_gnt(0, lat);
    req[0] = 1'b0;
    wait_rvalid(0, lat);
    check("b2b_busy_in_resp", {63'd0, busy}, 64'd1);
    set_core(0, 1'b0, 16'h0030, 8'h00);
    push_cmd(0, 1'b0, 16'h0030, 8'h00);
    rsp_q.push_back('{rvalid: 2'b01, rdata: 8'h1C});
    wait_gnt(0, lat);
    check("b2b_gnt_after_rvalid", lat, 1);
    req[0] = 1'b0;
    wait_rvalid(0, lat);
    check("b2b_read_latency", lat, 3);
    repeat (3) @(negedge clock);

    // Contention: four writes per core, served in rotation.
    rem[0] = 4; rem[1] = 4;
    for (int k = 0; k < 8; k++) begin
      w = pick_model({rem[1] != 0, rem[0] != 0}, tb_last);
      push_cmd(w, 1'b1, 16'(16'h0200 + w * 16'h0100), 8'(w * 16 + (4 - rem[w])));
      rem[w]--;
    end
    grants[0] = 0; grants[1] = 0; prev_cyc = -1;
    set_core(0, 1'b1, 16'h0200, 8'h00);
    set_core(1, 1'b1, 16'h0300, 8'h10);
    for (int n = 0; n < 60 && req != 2'b00; n++) begin
      @(negedge clock);
      for (int c = 0; c < 2; c++) begin
        if (gnt[c]) begin
          if (prev_cyc >= 0) check("contention_spacing", cyc - prev_cyc, 2);
          prev_cyc = cyc;
          grants[c]++;
          if (grants[c] == 4) req[c] = 1'b0;
          else wdata[c*8 +: 8] = 8'(c * 16 + grants[c]);
        end
      end
    end
    check("contention_grants_core0", grants[0], 4);
    check("contention_grants_core1", grants[1], 4);
    req = 2'b00;
    repeat (3) @(negedge clock);

    // Reset in the cycle after a read grant: response dropped, pointer restored.
    set_core(0, 1'b0, 16'h0011, 8'h00);
    push_cmd(0, 1'b0, 16'h0011, 8'h00);
    wait_gnt(0, lat);
    req[0] = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("midread_reset_outputs", {25'd0, gnt, rvalid, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    tb_last = 1;
    push_cmd(0, 1'b1, 16'h0180, 8'h77);
    push_cmd(1, 1'b1, 16'h0181, 8'h88);
    set_core(0, 1'b1, 16'h0180, 8'h77);
    set_core(1, 1'b1, 16'h0181, 8'h88);
    reset_n = 1'b1;
    rv_seen = 0;
    @(negedge clock);
    check("post_reset_first_gnt", {62'd0, gnt}, 64'd1);
    req[0] = 1'b0;
    wait_gnt(1, lat);
    req[1] = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (rvalid != 2'b00) rv_seen++;
    end
    check("no_rvalid_after_midread_reset", rv_seen, 0);

    check("cmd_queue_drained", cmd_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
